// File: rtl/pc_pkg.sv
// Shared constants for the program-counter unit: next-PC source encodings,
// the sequential increment and the word-alignment mask.
package pc_pkg;

    localparam logic [2:0] PC_SEL_SEQ  = 3'd0;
    localparam logic [2:0] PC_SEL_BR   = 3'd1;
    localparam logic [2:0] PC_SEL_J    = 3'd2;
    localparam logic [2:0] PC_SEL_JR   = 3'd3;
    localparam logic [2:0] PC_SEL_CALL = 3'd4;
    localparam logic [2:0] PC_SEL_RET  = 3'd5;

    localparam int unsigned PC_INC = 4;

    // Wide enough for any PC_W up to 64; callers slice [PC_W-1:0].
    localparam logic [63:0] PC_ALIGN_MASK = ~64'h3;

endpackage

// File: rtl/pc_unit_if.sv
// Control and status bundle between the fetch logic (master) and pc_unit (slave).
interface pc_unit_if #(
    parameter int unsigned PC_W = 32
);
    logic            en;
    logic [2:0]      sel;
    logic            br_taken;
    logic [15:0]     br_off;
    logic [25:0]     j_target;
    logic [PC_W-1:0] jr_target;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_plus4;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_err;

    modport master (
        output en, sel, br_taken, br_off, j_target, jr_target,
        input  pc, pc_plus4, ras_empty, ras_full, ras_err
    );

    modport slave (
        input  en, sel, br_taken, br_off, j_target, jr_target,
        output pc, pc_plus4, ras_empty, ras_full, ras_err
    );
endinterface

// File: rtl/return_address_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored; both misuse cases set a sticky error flag.
module return_address_stack
    import pc_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full,
    output logic         err
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] top_q, top_d, top_next, top_prev;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             err_q, err_d;

    // top_q is the next free slot; the most recent entry sits just below it.
    always_comb begin
        top_next = (top_q == PTR_W'(DEPTH - 1)) ? '0 : top_q + PTR_W'(1);
        top_prev = (top_q == '0) ? PTR_W'(DEPTH - 1) : top_q - PTR_W'(1);
    end

    assign dout  = mem_q[top_prev];
    assign empty = empty_q;
    assign full  = full_q;
    assign err   = err_q;

    always_comb begin
        mem_d = mem_q;
        top_d = top_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (push) begin
            mem_d[top_q] = din;
            top_d        = top_next;
            if (cnt_q == CNT_W'(DEPTH)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            if (cnt_q == '0) begin
                err_d = 1'b1;
            end else begin
                top_d = top_prev;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            top_q   <= top_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Contents need no reset: a zero count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit with sequential/branch/jump/call/return next-PC selection.
// Define PC_RAS_EN to build the return-address stack; otherwise CALL acts as J and RET as JR.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_VECTOR = '0,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic       clk,
    input  logic       rst,
    pc_unit_if.slave   bus
);
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] br_disp;
    logic [PC_W-1:0] j_addr;
    logic [PC_W-1:0] jr_addr;
    logic [PC_W-1:0] ras_top;
    logic            ras_hit;

    assign pc_plus4 = pc_q + PC_W'(PC_INC);
    assign br_disp  = {{(PC_W - 18){bus.br_off[15]}}, bus.br_off, 2'b00};
    assign j_addr   = {pc_plus4[PC_W-1:28], bus.j_target, 2'b00};
    assign jr_addr  = bus.jr_target & PC_ALIGN_MASK[PC_W-1:0];

`ifdef PC_RAS_EN
    logic ras_push, ras_pop, ras_empty_w, ras_full_w, ras_err_w;

    assign ras_push = bus.en && (bus.sel == PC_SEL_CALL);
    assign ras_pop  = bus.en && (bus.sel == PC_SEL_RET);
    assign ras_hit  = !ras_empty_w;

    return_address_stack #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus4),
        .dout  (ras_top),
        .empty (ras_empty_w),
        .full  (ras_full_w),
        .err   (ras_err_w)
    );

    assign bus.ras_empty = ras_empty_w;
    assign bus.ras_full  = ras_full_w;
    assign bus.ras_err   = ras_err_w;
`else
    assign ras_hit       = 1'b0;
    assign ras_top       = '0;
    assign bus.ras_empty = 1'b1;
    assign bus.ras_full  = 1'b0;
    assign bus.ras_err   = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (bus.en) begin
            case (bus.sel)
                PC_SEL_BR:   pc_d = bus.br_taken ? pc_plus4 + br_disp : pc_plus4;
                PC_SEL_J:    pc_d = j_addr;
                PC_SEL_CALL: pc_d = j_addr;
                PC_SEL_JR:   pc_d = jr_addr;
                PC_SEL_RET:  pc_d = ras_hit ? ras_top : jr_addr;
                default:     pc_d = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;

endmodule

// File: tb/tb_pc_unit.sv
// Directed, table-driven bench for pc_unit; expectations adapt to whether PC_RAS_EN is defined.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int unsigned PC_W = 32;
`ifdef PC_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pc_unit_if #(.PC_W(PC_W)) bus ();

    pc_unit #(
        .PC_W         (PC_W),
        .RESET_VECTOR (32'h100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [2:0]  sel;
        logic        bt;
        logic [15:0] off;
        logic [25:0] jt;
        logic [31:0] jrt;
        logic [31:0] pc;
        logic        e;
        logic        f;
        logic        er;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // pc_r/pc_n: expected pc with/without the RAS; e/f/er are RAS-build flag expectations.
    task automatic add(input logic r, input logic en, input logic [2:0] sel, input logic bt,
                       input logic [15:0] off, input logic [25:0] jt, input logic [31:0] jrt,
                       input logic [31:0] pc_r, input logic [31:0] pc_n,
                       input logic e, input logic f, input logic er);
        vec_t v;
        v.rst = r; v.en = en; v.sel = sel; v.bt = bt; v.off = off; v.jt = jt; v.jrt = jrt;
        v.pc  = RAS ? pc_r : pc_n;
        v.e   = RAS ? e : 1'b1;
        v.f   = RAS ? f : 1'b0;
        v.er  = RAS ? er : 1'b0;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [31:0] pc, input logic e,
                             input logic f, input logic er);
        cmp("pc", idx, bus.pc, pc);
        cmp("pc_plus4", idx, bus.pc_plus4, pc + 32'd4);
        cmp("ras_empty", idx, {31'd0, bus.ras_empty}, {31'd0, e});
        cmp("ras_full", idx, {31'd0, bus.ras_full}, {31'd0, f});
        cmp("ras_err", idx, {31'd0, bus.ras_err}, {31'd0, er});
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst          = v.rst;
        bus.en       = v.en;
        bus.sel      = v.sel;
        bus.br_taken = v.bt;
        bus.br_off   = v.off;
        bus.j_target = v.jt;
        bus.jr_target = v.jrt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        bus.en = 1'b1; bus.sel = PC_SEL_SEQ; bus.br_taken = 1'b0; bus.br_off = '0;
        bus.j_target = '0; bus.jr_target = '0;

        // Reset held for two cycles, the second with en low: reset wins.
        v = '{rst: 1'b1, en: 1'b1, sel: PC_SEL_J, bt: 1'b0, off: 16'h0, jt: 26'h3,
              jrt: 32'h0, pc: 32'h0, e: 1'b1, f: 1'b0, er: 1'b0};
        drive(v);
        check_all(-2, 32'h100, 1'b1, 1'b0, 1'b0);
        v.en = 1'b0;
        drive(v);
        check_all(-1, 32'h100, 1'b1, 1'b0, 1'b0);

        //   rst en sel          bt  off       jt          jrt            pc_r           pc_n           e  f  er
        add(0, 1, PC_SEL_SEQ,  0, 16'h0,    26'h0,      32'h0,         32'h104,       32'h104,       1, 0, 0);
        add(0, 1, PC_SEL_SEQ,  0, 16'h0,    26'h0,      32'h0,         32'h108,       32'h108,       1, 0, 0);
        add(0, 1, 3'd6,        0, 16'h0,    26'h0,      32'h0,         32'h10C,       32'h10C,       1, 0, 0);
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'h200,       32'h200,       32'h200,       1, 0, 0);
        add(0, 1, PC_SEL_BR,   1, 16'hFFFE, 26'h0,      32'h0,         32'h1FC,       32'h1FC,       1, 0, 0);
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'h200,       32'h200,       32'h200,       1, 0, 0);
        add(0, 1, PC_SEL_BR,   0, 16'hFFFE, 26'h0,      32'h0,         32'h204,       32'h204,       1, 0, 0);
        add(0, 0, PC_SEL_J,    0, 16'h0,    26'h3FFFFFF, 32'h0,        32'h204,       32'h204,       1, 0, 0);
        add(0, 0, PC_SEL_JR,   0, 16'h0,    26'h0,      32'h888,       32'h204,       32'h204,       1, 0, 0);
        add(0, 0, PC_SEL_CALL, 0, 16'h0,    26'h10,     32'h0,         32'h204,       32'h204,       1, 0, 0);
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'h1000,      32'h1000,      32'h1000,      1, 0, 0);
        add(0, 1, PC_SEL_J,    0, 16'h0,    26'h40,     32'h0,         32'h100,       32'h100,       1, 0, 0);
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'h303,       32'h300,       32'h300,       1, 0, 0);
        // Nested call/return
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'h10,        32'h10,        32'h10,        1, 0, 0);
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h8,      32'h0,         32'h20,        32'h20,        0, 0, 0);
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h10,     32'h0,         32'h40,        32'h40,        0, 0, 0);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h3FC,       32'h24,        32'h3FC,       0, 0, 0);
        add(0, 0, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h0,         32'h24,        32'h3FC,       0, 0, 0);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h3FC,       32'h14,        32'h3FC,       1, 0, 0);
        // Five calls into a four-deep stack
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'h14,        32'h14,        32'h14,        1, 0, 0);
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h40,     32'h0,         32'h100,       32'h100,       0, 0, 0);
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h80,     32'h0,         32'h200,       32'h200,       0, 0, 0);
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'hC0,     32'h0,         32'h300,       32'h300,       0, 0, 0);
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h100,    32'h0,         32'h400,       32'h400,       0, 1, 0);
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h140,    32'h0,         32'h500,       32'h500,       0, 1, 1);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h80,        32'h404,       32'h80,        0, 0, 1);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h80,        32'h304,       32'h80,        0, 0, 1);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h80,        32'h204,       32'h80,        0, 0, 1);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h80,        32'h104,       32'h80,        1, 0, 1);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h80,        32'h80,        32'h80,        1, 0, 1);
        // Reset mid-sequence discards the pushed entry
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h10,     32'h0,         32'h40,        32'h40,        0, 0, 1);
        add(1, 1, PC_SEL_SEQ,  0, 16'h0,    26'h0,      32'h0,         32'h100,       32'h100,       1, 0, 0);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h53,        32'h50,        32'h50,        1, 0, 1);
        // Back-to-back CALL then RET
        add(0, 1, PC_SEL_CALL, 0, 16'h0,    26'h30,     32'h0,         32'hC0,        32'hC0,        0, 0, 1);
        add(0, 1, PC_SEL_RET,  0, 16'h0,    26'h0,      32'h0,         32'h54,        32'h0,         1, 0, 1);
        // Wrap-around and upper-bit carry into J
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'hFFFFFFFC,  32'hFFFFFFFC,  32'hFFFFFFFC,  1, 0, 1);
        add(0, 1, 3'd7,        0, 16'h0,    26'h0,      32'h0,         32'h0,         32'h0,         1, 0, 1);
        add(0, 1, PC_SEL_JR,   0, 16'h0,    26'h0,      32'hF0000000,  32'hF0000000,  32'hF0000000,  1, 0, 1);
        add(0, 1, PC_SEL_J,    0, 16'h0,    26'h10,     32'h0,         32'hF0000040,  32'hF0000040,  1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check_all(i, vecs[i].pc, vecs[i].e, vecs[i].f, vecs[i].er);
        end

        // Three-cycle stall with RAS-affecting selects, then resume.
        for (int k = 0; k < 3; k++) begin
            v = '{rst: 1'b0, en: 1'b0, sel: (k == 0) ? PC_SEL_CALL : PC_SEL_RET, bt: 1'b1,
                  off: 16'h10, jt: 26'h5, jrt: 32'h44, pc: 32'h0, e: 1'b0, f: 1'b0, er: 1'b0};
            drive(v);
            check_all(100 + k, 32'hF0000040, 1'b1, 1'b0, RAS);
        end
        v = '{rst: 1'b0, en: 1'b1, sel: PC_SEL_BR, bt: 1'b1, off: 16'h4, jt: 26'h0,
              jrt: 32'h0, pc: 32'h0, e: 1'b0, f: 1'b0, er: 1'b0};
        drive(v);
        check_all(103, 32'hF0000054, 1'b1, 1'b0, RAS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
